// File: rtl/alu_muldiv_if.sv
// ---------------------------------------------------------------------------
// alu_muldiv_if
// Groups the EX-stage ALU / multiply-divide signals into one bundle.
//
// Ports (as interface members):
//   start, control, read1, foutput   : issue side, driven by the EX stage
//   out, zero, overflow              : combinational ALU results
//   busy, done, stall                : mult/div status and hazard request
//   hi, lo                           : architectural HI/LO registers
//   divzero                          : only when MULDIV_DIVZERO_EN is defined
//
// Modports: master = EX-stage driver, slave = the ALU itself.
// ---------------------------------------------------------------------------
interface alu_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [5:0]       control;
    logic [WIDTH-1:0] read1;
    logic [WIDTH-1:0] foutput;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             overflow;
    logic             busy;
    logic             done;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
`ifdef MULDIV_DIVZERO_EN
    logic             divzero;

    modport master (
        output start, control, read1, foutput,
        input  out, zero, overflow, busy, done, stall, hi, lo, divzero
    );

    modport slave (
        input  start, control, read1, foutput,
        output out, zero, overflow, busy, done, stall, hi, lo, divzero
    );
`else
    modport master (
        output start, control, read1, foutput,
        input  out, zero, overflow, busy, done, stall, hi, lo
    );

    modport slave (
        input  start, control, read1, foutput,
        output out, zero, overflow, busy, done, stall, hi, lo
    );
`endif
endinterface

// File: rtl/alu_muldiv.sv
// ---------------------------------------------------------------------------
// alu_muldiv
// EX-stage ALU for the MIPS core: single-cycle integer ops, branch compare,
// signed overflow, and an iterative multiply/divide unit with HI/LO.
//
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-high; aborts any mult/div, clears HI/LO
//   bus    : alu_muldiv_if.slave (start, control, read1, foutput in;
//            out, zero, overflow, busy, done, stall, hi, lo out)
//
// Parameters:
//   WIDTH  : datapath width (>= 4)
//   CNT_W  : iteration counter width (2**CNT_W > WIDTH)
//
// Optional macro MULDIV_DIVZERO_EN: a div/divu by zero skips the iteration
// phase (one busy cycle) and pulses bus.divzero together with done.
// ---------------------------------------------------------------------------
module alu_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic         clk,
    input logic         reset,
    alu_muldiv_if.slave bus
);
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_SLTIU = 6'd11;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_MFHI  = 6'd16;
    localparam logic [5:0] OP_MTHI  = 6'd17;
    localparam logic [5:0] OP_MFLO  = 6'd18;
    localparam logic [5:0] OP_MTLO  = 6'd19;
    localparam logic [5:0] OP_MULT  = 6'd24;
    localparam logic [5:0] OP_MULTU = 6'd25;
    localparam logic [5:0] OP_DIV   = 6'd26;
    localparam logic [5:0] OP_DIVU  = 6'd27;
    localparam logic [5:0] OP_ADD   = 6'd32;
    localparam logic [5:0] OP_SUB   = 6'd34;
    localparam logic [5:0] OP_AND   = 6'd36;
    localparam logic [5:0] OP_OR    = 6'd37;
    localparam logic [5:0] OP_NOR   = 6'd39;
    localparam logic [5:0] OP_SLT   = 6'd42;
    localparam logic [5:0] OP_SLTU  = 6'd43;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH-1:0]     opa;
    logic [WIDTH-1:0]     opb;
    logic [2*WIDTH-1:0]   prod;
    logic                 is_div;
    logic                 neg_res;
    logic                 neg_rem;
    logic                 dz;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;
    logic                 busy_r;
    logic                 done_r;
`ifdef MULDIV_DIVZERO_EN
    logic                 divzero_r;
`endif

    logic [WIDTH-1:0]     a, b, sum, diff, res;
    logic                 ovf, zflag;
    logic                 is_md, div_op, is_signed, sa, sb, stall_code;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH:0]       madd, shifted;
    logic [WIDTH-1:0]     trial;
    logic                 ge;
    logic [2*WIDTH-1:0]   mul_next, div_next, prod_neg;
    logic [WIDTH-1:0]     quot_fix, rem_fix, dvd_fix;

    assign a    = bus.read1;
    assign b    = bus.foutput;
    assign sum  = a + b;
    assign diff = a - b;

    // Single-cycle result mux; mult/div and unknown codes read as zero.
    always_comb begin
        res = '0;
        case (bus.control)
            OP_AND, OP_ANDI:   res = a & b;
            OP_OR, OP_ORI:     res = a | b;
            OP_NOR:            res = ~(a | b);
            OP_ADD, OP_ADDI:   res = sum;
            OP_SUB:            res = diff;
            OP_SLT, OP_SLTI:   res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU, OP_SLTIU: res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_MFHI:           res = hi_r;
            OP_MFLO:           res = lo_r;
            default:           res = '0;
        endcase
    end

    // Signed overflow and branch compare flags.
    always_comb begin
        ovf   = 1'b0;
        zflag = 1'b0;
        case (bus.control)
            OP_ADD, OP_ADDI: ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            OP_SUB:          ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            OP_BEQ:          zflag = (a == b);
            OP_BNE:          zflag = (a != b);
            default: begin
                ovf   = 1'b0;
                zflag = 1'b0;
            end
        endcase
    end

    assign div_op     = (bus.control == OP_DIV) || (bus.control == OP_DIVU);
    assign is_md      = div_op || (bus.control == OP_MULT) || (bus.control == OP_MULTU);
    assign is_signed  = (bus.control == OP_MULT) || (bus.control == OP_DIV);
    assign stall_code = is_md || (bus.control == OP_MFHI) || (bus.control == OP_MTHI) ||
                        (bus.control == OP_MFLO) || (bus.control == OP_MTLO);

    // The iterative core works on magnitudes; signs are reapplied in FIX.
    assign sa    = is_signed & a[WIDTH-1];
    assign sb    = is_signed & b[WIDTH-1];
    assign abs_a = sa ? -a : a;
    assign abs_b = sb ? -b : b;

    // Multiply step: prod holds {partial, multiplier}; add opa when lsb set, shift right.
    assign madd     = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opa} : '0);
    assign mul_next = {madd, prod[WIDTH-1:1]};

    // Restoring divide step: prod holds {remainder, quotient}. The shifted
    // remainder needs WIDTH+1 bits; when it fits the divisor the difference
    // is below the divisor, so WIDTH bits of it are exact.
    assign shifted  = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    assign ge       = (shifted >= {1'b0, opb});
    assign trial    = shifted[WIDTH-1:0] - opb;
    assign div_next = {(ge ? trial : shifted[WIDTH-1:0]), prod[WIDTH-2:0], ge};

    assign prod_neg = -prod;
    assign quot_fix = neg_res ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
    assign rem_fix  = neg_rem ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
    // Divide by zero returns the original dividend, rebuilt from its magnitude.
    assign dvd_fix  = neg_rem ? -opa : opa;

    // Multiply/divide sequencer plus HI/LO registers. Issue and mthi/mtlo
    // are only honoured in IDLE, so anything sent while busy is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            opa     <= '0;
            opb     <= '0;
            prod    <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dz      <= 1'b0;
            hi_r    <= '0;
            lo_r    <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
            divzero_r <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
            divzero_r <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.start && is_md) begin
                        opa     <= abs_a;
                        opb     <= abs_b;
                        is_div  <= div_op;
                        neg_res <= sa ^ sb;
                        neg_rem <= sa;
                        dz      <= div_op && (b == '0);
                        prod    <= div_op ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
                        cnt     <= '0;
                        busy_r  <= 1'b1;
`ifdef MULDIV_DIVZERO_EN
                        state   <= (div_op && (b == '0)) ? FIX : RUN;
`else
                        state   <= RUN;
`endif
                    end else if (bus.start && (bus.control == OP_MTHI)) begin
                        hi_r <= a;
                    end else if (bus.start && (bus.control == OP_MTLO)) begin
                        lo_r <= a;
                    end
                end
                RUN: begin
                    prod <= is_div ? div_next : mul_next;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (!is_div) begin
                        {hi_r, lo_r} <= neg_res ? prod_neg : prod;
                    end else if (dz) begin
                        hi_r <= dvd_fix;
                        lo_r <= '1;
                    end else begin
                        hi_r <= rem_fix;
                        lo_r <= quot_fix;
                    end
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
`ifdef MULDIV_DIVZERO_EN
                    divzero_r <= dz;
`endif
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out      = res;
    assign bus.zero     = zflag;
    assign bus.overflow = ovf;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.stall    = busy_r && stall_code;
    assign bus.hi       = hi_r;
    assign bus.lo       = lo_r;
`ifdef MULDIV_DIVZERO_EN
    assign bus.divzero  = divzero_r;
`endif
endmodule

// File: tb/tb_alu_muldiv.sv
// ---------------------------------------------------------------------------
// tb_alu_muldiv
// Self-checking bench for alu_muldiv: directed and random stimulus compared
// against an arithmetic reference model (64-bit integer math for mult/div).
// Honours MULDIV_DIVZERO_EN when it is defined for the build.
// ---------------------------------------------------------------------------
module tb_alu_muldiv;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    alu_muldiv_if #(.WIDTH(WIDTH)) bus ();

    alu_muldiv #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference copies of HI/LO.
    logic [31:0] mhi;
    logic [31:0] mlo;

    // Every comparison funnels through here.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive a new command on the falling edge, away from the sampling edge.
    task automatic applyStimulus(input logic [5:0] code, input logic [31:0] a,
                                 input logic [31:0] b, input logic st);
        @(negedge clk);
        bus.control = code;
        bus.read1   = a;
        bus.foutput = b;
        bus.start   = st;
    endtask

    function automatic logic [31:0] modelOut(input logic [5:0] code, input logic [31:0] a,
                                             input logic [31:0] b);
        case (code)
            6'd32, 6'd8:  return a + b;
            6'd34:        return a - b;
            6'd36, 6'd12: return a & b;
            6'd37, 6'd13: return a | b;
            6'd39:        return ~(a | b);
            6'd42, 6'd10: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'd43, 6'd11: return (a < b) ? 32'd1 : 32'd0;
            6'd16:        return mhi;
            6'd18:        return mlo;
            default:      return 32'd0;
        endcase
    endfunction

    // Overflow = exact signed result does not fit in 32 bits.
    function automatic logic modelOverflow(input logic [5:0] code, input logic [31:0] a,
                                           input logic [31:0] b);
        longint r;
        if (code == 6'd32 || code == 6'd8)
            r = longint'($signed(a)) + longint'($signed(b));
        else if (code == 6'd34)
            r = longint'($signed(a)) - longint'($signed(b));
        else
            return 1'b0;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    function automatic logic modelZero(input logic [5:0] code, input logic [31:0] a,
                                       input logic [31:0] b);
        if (code == 6'd4) return a == b;
        if (code == 6'd5) return a != b;
        return 1'b0;
    endfunction

    // Updates mhi/mlo with the architectural result of a mult/div.
    task automatic modelMulDiv(input logic [5:0] code, input logic [31:0] a,
                               input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (code)
            6'd24: begin
                p = 64'(sa * sb);
                mhi = p[63:32];
                mlo = p[31:0];
            end
            6'd25: begin
                p = {32'd0, a} * {32'd0, b};
                mhi = p[63:32];
                mlo = p[31:0];
            end
            6'd26: begin
                if (b == 32'd0) begin
                    mhi = a;
                    mlo = 32'hFFFF_FFFF;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    mhi = r[31:0];
                    mlo = q[31:0];
                end
            end
            default: begin
                if (b == 32'd0) begin
                    mhi = a;
                    mlo = 32'hFFFF_FFFF;
                end else begin
                    mhi = a % b;
                    mlo = a / b;
                end
            end
        endcase
    endtask

    task automatic combTest(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b);
        applyStimulus(code, a, b, 1'b0);
        #2;
        checkOutput($sformatf("out c%0d", code), 64'(bus.out), 64'(modelOut(code, a, b)));
        checkOutput($sformatf("overflow c%0d", code), 64'(bus.overflow), 64'(modelOverflow(code, a, b)));
        checkOutput($sformatf("zero c%0d", code), 64'(bus.zero), 64'(modelZero(code, a, b)));
        checkOutput($sformatf("stall idle c%0d", code), 64'(bus.stall), 64'd0);
    endtask

    // Issue one mult/div and check busy length, done timing and HI/LO.
    task automatic runMulDiv(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b);
        int busyCnt;
        int doneAt;
        int expBusy;
        busyCnt = 0;
        doneAt  = 0;
        expBusy = WIDTH + 1;
`ifdef MULDIV_DIVZERO_EN
        if ((code == 6'd26 || code == 6'd27) && b == 32'd0) expBusy = 1;
`endif
        applyStimulus(code, a, b, 1'b1);
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (bus.done) begin
                doneAt = k;
                break;
            end
            if (bus.busy) busyCnt++;
        end
        modelMulDiv(code, a, b);
        checkOutput($sformatf("busy cycles c%0d", code), 64'(busyCnt), 64'(expBusy));
        checkOutput($sformatf("done latency c%0d", code), 64'(doneAt), 64'(expBusy + 1));
        checkOutput($sformatf("busy at done c%0d", code), 64'(bus.busy), 64'd0);
        checkOutput($sformatf("hi c%0d a=%0h b=%0h", code, a, b), 64'(bus.hi), 64'(mhi));
        checkOutput($sformatf("lo c%0d a=%0h b=%0h", code, a, b), 64'(bus.lo), 64'(mlo));
`ifdef MULDIV_DIVZERO_EN
        checkOutput("divzero pulse", 64'(bus.divzero),
                    64'(((code == 6'd26 || code == 6'd27) && b == 32'd0) ? 1 : 0));
`endif
        @(negedge clk);
        checkOutput("done one cycle", 64'(bus.done), 64'd0);
    endtask

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Watchdog so a stuck design still ends the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [5:0] codes [19];
        logic [31:0] ra, rb;
        int doneSeen;
        codes = '{6'd32, 6'd8, 6'd34, 6'd36, 6'd12, 6'd37, 6'd13, 6'd39, 6'd42, 6'd10,
                  6'd43, 6'd11, 6'd16, 6'd18, 6'd4, 6'd5, 6'd0, 6'd24, 6'd50};
        mhi = 32'd0;
        mlo = 32'd0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.control = 6'd24;
        bus.read1   = 32'd1;
        bus.foutput = 32'd2;

        // Reset state, with combinational outputs still live.
        repeat (3) @(negedge clk);
        checkOutput("reset busy", 64'(bus.busy), 64'd0);
        checkOutput("reset done", 64'(bus.done), 64'd0);
        checkOutput("reset stall", 64'(bus.stall), 64'd0);
        checkOutput("reset hi", 64'(bus.hi), 64'd0);
        checkOutput("reset lo", 64'(bus.lo), 64'd0);
        bus.control = 6'd32;
        #1;
        checkOutput("reset out add", 64'(bus.out), 64'd3);
        @(negedge clk);
        reset = 1'b0;

        // Directed combinational cases.
        combTest(6'd32, 32'h7FFF_FFFF, 32'h0000_0001);
        combTest(6'd34, 32'h8000_0000, 32'h0000_0001);
        combTest(6'd42, 32'hFFFF_FFFF, 32'h0000_0001);
        combTest(6'd43, 32'hFFFF_FFFF, 32'h0000_0001);
        combTest(6'd4, 32'd5, 32'd5);
        combTest(6'd5, 32'd5, 32'd5);

        // Directed mult/div cases, then read back through mfhi/mflo.
        runMulDiv(6'd24, -32'sd3, 32'd7);
        combTest(6'd16, 32'd0, 32'd0);
        combTest(6'd18, 32'd0, 32'd0);
        runMulDiv(6'd26, -32'sd7, 32'd2);
        runMulDiv(6'd27, 32'd100, 32'd7);
        runMulDiv(6'd27, 32'd9, 32'd0);
        runMulDiv(6'd26, -32'sd5, 32'd0);

        // Busy-window hazards: mflo and a second mult while busy.
        applyStimulus(6'd24, 32'd6, 32'd9, 1'b1);
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.control = 6'd18;
        #1;
        checkOutput("stall mflo busy", 64'(bus.stall), 64'd1);
        checkOutput("mflo old lo", 64'(bus.out), 64'(mlo));
        applyStimulus(6'd24, 32'd1000, 32'd1000, 1'b1);
        #1;
        checkOutput("stall mult busy", 64'(bus.stall), 64'd1);
        @(posedge clk);
        #1 bus.start = 1'b0;
        doneSeen = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.done) begin
                doneSeen = 1;
                break;
            end
        end
        modelMulDiv(6'd24, 32'd6, 32'd9);
        checkOutput("hazard done", 64'(doneSeen), 64'd1);
        checkOutput("hazard hi", 64'(bus.hi), 64'(mhi));
        checkOutput("hazard lo", 64'(bus.lo), 64'(mlo));
        @(negedge clk);
        checkOutput("second mult ignored", 64'(bus.busy), 64'd0);

        // mthi after done.
        applyStimulus(6'd17, 32'h1234, 32'd0, 1'b1);
        @(posedge clk);
        #1 bus.start = 1'b0;
        mhi = 32'h1234;
        @(negedge clk);
        checkOutput("mthi hi", 64'(bus.hi), 64'(mhi));
        checkOutput("mthi lo kept", 64'(bus.lo), 64'(mlo));
        applyStimulus(6'd19, 32'hCAFE, 32'd0, 1'b1);
        @(posedge clk);
        #1 bus.start = 1'b0;
        mlo = 32'hCAFE;
        @(negedge clk);
        checkOutput("mtlo lo", 64'(bus.lo), 64'(mlo));

        // Reset in the middle of RUN aborts without a write.
        applyStimulus(6'd24, 32'd123, 32'd456, 1'b1);
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        mhi = 32'd0;
        mlo = 32'd0;
        @(negedge clk);
        checkOutput("abort busy", 64'(bus.busy), 64'd0);
        checkOutput("abort hi", 64'(bus.hi), 64'd0);
        checkOutput("abort lo", 64'(bus.lo), 64'd0);
        doneSeen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done) doneSeen = 1;
        end
        checkOutput("abort no done", 64'(doneSeen), 64'd0);

        // Random combinational traffic.
        for (int i = 0; i < 40; i++) begin
            ra = randOperand();
            rb = ($urandom_range(0, 3) == 0) ? ra : randOperand();
            combTest(codes[$urandom_range(0, 18)], ra, rb);
        end

        // Random mult/div traffic.
        for (int i = 0; i < 12; i++) begin
            ra = randOperand();
            rb = randOperand();
            runMulDiv(6'(24 + $urandom_range(0, 3)), ra, rb);
        end
        combTest(6'd16, 32'd0, 32'd0);
        combTest(6'd18, 32'd0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised next-generation datapath ALU for the MIPS core: single-cycle integer ops plus an iterative multiply/divide unit with HI/LO registers.
- Sits in EX. Operands come from the register file (read1) and the immediate/forward mux (foutput); control is the decoded funct/opcode.
- Adds signed overflow, branch compare, MULT/MULTU/DIV/DIVU, MFHI/MFLO/MTHI/MTLO, and a stall output to the hazard unit.

Parameters:
- WIDTH, 32: operand, result, HI and LO width. Must be at least 4.
- CNT_W, 6: iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: issue qualifier for mult/div/mthi/mtlo.
- control, input, 6: operation code.
- read1, input, WIDTH: operand A (rs).
- foutput, input, WIDTH: operand B (rt or immediate).
- out, output, WIDTH: combinational result.
- zero, output, 1: branch-taken flag.
- overflow, output, 1: signed overflow for add/addi/sub.
- busy, output, 1: mult/div in progress.
- done, output, 1: one-cycle pulse; HI/LO hold the new result.
- stall, output, 1: EX must hold its instruction.
- hi, output, WIDTH: HI register.
- lo, output, WIDTH: LO register.

Behaviour:
- Combinational ops (same cycle, no state):
  - 36/12 and; 37/13 or; 39 nor.
  - 32/8 add; 34 sub.
  - 42/10 slt, signed: out = 1 if read1 < foutput, else 0, zero-extended.
  - 43/11 sltu, unsigned compare.
  - 16 mfhi: out = hi. 18 mflo: out = lo.
  - Any other code: out = 0.
- overflow:
  - Asserted only for codes 32, 8, 34, when the operand signs match the add case (or differ for sub) and the result sign differs.
  - Otherwise 0. out still carries the wrapped sum.
- zero:
  - Code 4: 1 when read1 == foutput.
  - Code 5: 1 when read1 != foutput.
  - Otherwise 0.
- Mult/div codes: 24 mult, 25 multu, 26 div, 27 divu. out = 0 for these codes.
- FSM states: IDLE, RUN, FIX.
  - IDLE: start=1 with a mult/div code and busy=0 latches the operands. Signed ops latch absolute values and record the sign flags. Counter is cleared; go to RUN.
  - RUN: one iteration per clock for WIDTH clocks.
    - Mult: shift-add into a 2*WIDTH product.
    - Div: restoring, 1 quotient bit per clock.
    - After the WIDTH-th iteration, go to FIX.
  - FIX: apply sign correction.
    - Product negated if the signs differ.
    - Quotient negated if the signs differ; remainder takes the dividend's sign.
    - Write hi = product high or remainder; lo = product low or quotient. Go to IDLE.
  - done = 1 in the cycle after FIX, for exactly one cycle.
- Timing:
  - busy = 1 in RUN and FIX, i.e. exactly WIDTH+1 cycles after the issue edge.
  - Issue-to-done latency is WIDTH+2 cycles.
- Divide by zero (divisor 0): hi = original dividend; lo = all ones; no sign correction.
- mthi (17) / mtlo (19): with start=1 and busy=0, write read1 to hi or lo at the clock edge.
- stall = busy AND (code is a mult/div/mfhi/mflo/mthi/mtlo). Commands issued while busy are ignored, not queued.
- Start in the done cycle is accepted, since busy=0.
- HI/LO are unchanged while busy. They update only in FIX or via mthi/mtlo.
- Reset, including mid-operation: state IDLE; counter 0; hi = lo = 0; busy = done = 0. The operation is aborted with no write.
- All outputs on reset: out, zero and overflow follow their inputs; stall = 0.

Optional Feature:
- Macro: MULDIV_DIVZERO_EN.
- Defined:
  - Divisor 0 on div/divu skips RUN and goes to FIX directly.
  - busy lasts 1 cycle; done follows on the next cycle.
  - Extra output port divzero (1 bit), pulsed together with done.
- Undefined:
  - Divide by zero takes the full WIDTH+1 busy cycles and gives the same hi/lo values.
  - No divzero port.

Test Plan:
- Combinational ops:
  - add 0x7FFFFFFF + 0x00000001 (code 32) -> out = 0x80000000, overflow = 1.
  - sub 0x80000000 - 1 (code 34) -> overflow = 1.
  - slt -1 < 1 (code 42) -> out = 1; sltu (code 43) -> out = 0.
- Branch compare: code 4 with 5/5 -> zero = 1; code 5 with 5/5 -> zero = 0.
- Signed mult: mult -3 * 7 -> busy for 33 cycles, done pulse at cycle 34; hi = 0xFFFFFFFF, lo = 0xFFFFFFEB. Then mfhi/mflo read these values.
- Signed divide:
  - div -7 / 2 -> lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1).
  - divu 100 / 7 -> lo = 14, hi = 2.
- Busy-window hazards: issue mult, then while busy issue mflo and a second mult -> stall = 1, the second mult is ignored, HI/LO change only once. Then:
  - mthi 0x1234 after done -> hi = 0x1234.
  - reset at RUN cycle 10 -> busy = 0, hi = lo = 0, no done.
- Divide by zero: divu 9 / 0 -> hi = 9, lo = 0xFFFFFFFF.
  - Latency 33 busy cycles without the macro.
  - 1 busy cycle and a divzero pulse with MULDIV_DIVZERO_EN.
